rx_word_align: RTL and testbench
================================

# rx_word_align

Word-alignment controller for the receive side of the serial link. It runs on the receiver bit clock and watches the 10-bit shift window produced by the serial-to-parallel converter. It hunts for the K28.5 comma, establishes the 10-bit word boundary, and reports lock. Once locked, it emits one aligned 10-bit word every ten bit clocks to the 8b/10b decoder.

## Interface
- ACQ_COMMAS, 3: boundary-aligned commas needed to move from VERIFY to LOCKED (1..15).
- LOSS_THRESH, 4: consecutive misaligned commas that drop lock (1..15).
- CRC_CKL  in  1  receiver bit clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- en  in  1  alignment enable; 0 forces HUNT with counters cleared, same effect as RESET except realign_cnt is kept.
- rx_window  in  10  current shift window; bit 0 is the oldest bit (first transmitted, 8b/10b bit "a"). Updates every clock.
- word_out  out  10  aligned word, valid only with word_valid.
- word_valid  out  1  one-cycle pulse per aligned word, only in LOCKED.
- word_is_comma  out  1  qualifies word_out as K28.5, either disparity.
- locked  out  1  high in LOCKED.
- bit_phase  out  4  phase counter 0..9; 9 marks a boundary window.
- realign_cnt  out  8  saturating count of LOCKED→HUNT transitions.

## Operation
- Comma: rx_window == 10'h17C (K28.5 RD−) or 10'h283 (RD+). Detection is combinational; all outputs are registered.
- States: HUNT, VERIFY, LOCKED.
- HUNT: on comma, load bit_phase := 0, good_cnt := 1, and go to VERIFY. Otherwise bit_phase holds at 0. No word_valid.
- bit_phase advances 0→9→0 every clock outside HUNT. A window is a boundary when bit_phase == 9.
- VERIFY, comma on a boundary: good_cnt++. When good_cnt reaches ACQ_COMMAS, go to LOCKED with err_cnt := 0.
- VERIFY, comma off a boundary: go back to HUNT, then reload as in HUNT on the same cycle (immediate re-acquire at the new phase).
- VERIFY, non-comma on a boundary: allowed, good_cnt unchanged.
- LOCKED, boundary: word_valid := 1, word_out := rx_window, word_is_comma := comma. An aligned comma clears err_cnt.
- LOCKED, comma off a boundary: err_cnt++. When it reaches LOSS_THRESH, go to HUNT, clear locked and err_cnt, and increment realign_cnt (saturating at 255). The phase is not reloaded on this cycle; the next comma re-acquires.
- A comma window only appears off a boundary on a phase mismatch, so an aligned and a misaligned comma cannot occur on the same cycle.

## Timing
- Reset values: state HUNT, word_out 0, word_valid 0, word_is_comma 0, locked 0, bit_phase 0, realign_cnt 0, good_cnt 0, err_cnt 0.
- Latency: rx_window sampled at edge t appears on word_out/word_valid after edge t, i.e. one clock.
- With a comma first seen at cycle t in HUNT, the next boundary windows are t+10, t+20, …
- With ACQ_COMMAS = 3 and commas every 10 bits: locked rises one clock after the cycle-t+20 window is sampled. The first word_valid is for the t+30 window.
- word_valid spacing in LOCKED is exactly 10 clocks. word_valid never occurs in HUNT or VERIFY.
- RESET or en = 0 mid-word takes effect on the next edge. Any pending word_valid is not issued.

## Structure
- Shared package rx_align_pkg: K28_5_RDN = 10'h17C, K28_5_RDP = 10'h283, WORD_BITS = 10, and the state enum {HUNT, VERIFY, LOCKED}.
- Sub-module rx_comma_det: combinational rx_window → is_comma, reused later by the decoder.
- Counters: good_cnt and err_cnt are 4 bits; bit_phase is 4 bits with an explicit wrap at 9.

## Test plan
- Reset/idle: RESET high for 3 clocks, then random non-comma windows for 200 clocks → all outputs 0, state HUNT.
- Acquire: comma 10'h17C every 10 clocks starting at cycle 5, data words in between → locked rises after the third comma. word_valid pulses every 10 clocks starting at the fourth boundary, with word_out matching the injected words.
- Both disparities: alternate 10'h17C / 10'h283 on the boundaries → lock is reached, and word_is_comma = 1 on each comma word.
- False comma in VERIFY: second comma arrives 3 clocks late → returns to HUNT, then re-acquires at the new phase, bit_phase = 0 the clock after the late comma.
- Loss of lock: after lock, shift the stream by 4 bits with commas every 10 → 4 misaligned commas, then locked drops and realign_cnt = 1. Re-lock follows at the new phase.
- Reset/enable mid-operation: en = 0 for one clock while LOCKED at bit_phase 5 → locked = 0, no word_valid, realign_cnt unchanged. Re-lock after three aligned commas.

Source files
------------

// File: rtl/rx_align_pkg.sv
// Shared constants and state type for the receive word-alignment path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_align_pkg;

  localparam int WORD_BITS = 10;

  // K28.5 comma in both running disparities, bit 0 = first transmitted bit "a".
  localparam logic [WORD_BITS-1:0] K28_5_RDN = 10'h17C;
  localparam logic [WORD_BITS-1:0] K28_5_RDP = 10'h283;

  localparam logic [3:0] PHASE_LAST = 4'd9;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

endpackage

// File: rtl/rx_word_align_comma_det.sv
// Combinational K28.5 detector (either disparity) on a 10-bit window.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; evaluates every window.
module rx_comma_det
  import rx_align_pkg::*;
(
  input  logic [WORD_BITS-1:0] window_i,
  output logic                 is_comma_o
);

  // Exact match against both disparities of the comma symbol.
  always_comb begin
    is_comma_o = (window_i == K28_5_RDN) || (window_i == K28_5_RDP);
  end

endmodule

// File: rtl/rx_word_align.sv
// Hunts for K28.5, verifies the word boundary, then emits one aligned word per ten bit clocks.
// Latency: one clock from the sampled boundary window to word_out/word_valid.
// Backpressure: none; the decoder must accept every word_valid pulse.
module rx_word_align
  import rx_align_pkg::*;
#(
  parameter int ACQ_COMMAS  = 3,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 CRC_CKL,
  input  logic                 RESET,
  input  logic                 en,
  input  logic [WORD_BITS-1:0] rx_window,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  output logic                 word_is_comma,
  output logic                 locked,
  output logic [3:0]           bit_phase,
  output logic [7:0]           realign_cnt
);

  align_state_e         state_q, state_d;
  logic [3:0]           phase_q, phase_d;
  logic [3:0]           good_q, good_d;
  logic [3:0]           err_q, err_d;
  logic [7:0]           realign_q, realign_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic                 wc_q, wc_d;
  logic                 wv_q, wv_d;
  logic                 locked_q, locked_d;

  logic                 is_comma;
  logic                 boundary;
  logic [3:0]           phase_adv;
  logic [4:0]           good_inc;
  logic [4:0]           err_inc;

  rx_comma_det u_comma_det (
    .window_i   (rx_window),
    .is_comma_o (is_comma)
  );

  // Next-state, counter and output decode for the alignment FSM.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    good_d    = good_q;
    err_d     = err_q;
    realign_d = realign_q;
    word_d    = word_q;
    wc_d      = wc_q;
    wv_d      = 1'b0;

    boundary  = (phase_q == PHASE_LAST);
    phase_adv = boundary ? 4'd0 : phase_q + 4'd1;
    good_inc  = {1'b0, good_q} + 5'd1;
    err_inc   = {1'b0, err_q} + 5'd1;

    unique case (state_q)
      HUNT: begin
        phase_d = 4'd0;
        if (is_comma) begin
          good_d  = 4'd1;
          state_d = VERIFY;
        end
      end

      VERIFY: begin
        phase_d = phase_adv;
        if (is_comma && boundary) begin
          good_d = good_inc[3:0];
          if (good_inc >= 5'(ACQ_COMMAS)) begin
            state_d = LOCKED;
            err_d   = 4'd0;
          end
        end else if (is_comma) begin
          // Off-boundary comma: drop back and re-acquire at this new phase at once.
          phase_d = 4'd0;
          good_d  = 4'd1;
        end
      end

      LOCKED: begin
        phase_d = phase_adv;
        if (boundary) begin
          wv_d   = 1'b1;
          word_d = rx_window;
          wc_d   = is_comma;
          if (is_comma) begin
            err_d = 4'd0;
          end
        end else if (is_comma) begin
          if (err_inc >= 5'(LOSS_THRESH)) begin
            // Lock lost; the next comma seen in HUNT sets the new phase.
            state_d   = HUNT;
            err_d     = 4'd0;
            phase_d   = 4'd0;
            realign_d = (realign_q != 8'hFF) ? realign_q + 8'd1 : realign_q;
          end else begin
            err_d = err_inc[3:0];
          end
        end
      end

      default: begin
        state_d = HUNT;
        phase_d = 4'd0;
      end
    endcase

    // Disable behaves like reset but keeps the realign history.
    if (!en) begin
      state_d = HUNT;
      phase_d = 4'd0;
      good_d  = 4'd0;
      err_d   = 4'd0;
      word_d  = '0;
      wc_d    = 1'b0;
      wv_d    = 1'b0;
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CRC_CKL) begin
    if (RESET) begin
      state_q   <= HUNT;
      phase_q   <= 4'd0;
      good_q    <= 4'd0;
      err_q     <= 4'd0;
      realign_q <= 8'd0;
      word_q    <= '0;
      wc_q      <= 1'b0;
      wv_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      good_q    <= good_d;
      err_q     <= err_d;
      realign_q <= realign_d;
      word_q    <= word_d;
      wc_q      <= wc_d;
      wv_q      <= wv_d;
      locked_q  <= locked_d;
    end
  end

  assign word_out      = word_q;
  assign word_valid    = wv_q;
  assign word_is_comma = wc_q;
  assign locked        = locked_q;
  assign bit_phase     = phase_q;
  assign realign_cnt   = realign_q;

endmodule

// File: tb/tb_rx_word_align.sv
// Randomized bench for rx_word_align against a cycle-indexed reference model.
// Latency: model predicts outputs one clock after each sampled window.
// Backpressure: n/a.
module tb_rx_word_align;

  localparam int ACQ  = 3;
  localparam int LOSS = 4;

  logic       CRC_CKL = 1'b0;
  logic       RESET   = 1'b1;
  logic       en      = 1'b1;
  logic [9:0] rx_window = 10'h000;
  logic [9:0] word_out;
  logic       word_valid;
  logic       word_is_comma;
  logic       locked;
  logic [3:0] bit_phase;
  logic [7:0] realign_cnt;

  rx_word_align #(.ACQ_COMMAS(ACQ), .LOSS_THRESH(LOSS)) dut (
    .CRC_CKL       (CRC_CKL),
    .RESET         (RESET),
    .en            (en),
    .rx_window     (rx_window),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_is_comma (word_is_comma),
    .locked        (locked),
    .bit_phase     (bit_phase),
    .realign_cnt   (realign_cnt)
  );

  always #5 CRC_CKL = ~CRC_CKL;

  int errors = 0;
  int checks = 0;

  // Reference model: the phase is derived from the cycle index of the
  // comma that anchored acquisition, not from a running counter.
  int cyc       = 0;
  int m_st      = 0;   // 0 hunting, 1 verifying, 2 locked
  int m_anchor  = 0;
  int m_good    = 0;
  int m_err     = 0;
  int m_realign = 0;
  bit m_wv      = 0;
  bit m_clr     = 0;
  int m_wo      = 0;
  bit m_wc      = 0;
  int off       = 0;
  bit disp      = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit is_k(input logic [9:0] w);
    return (w == 10'h17C) || (w == 10'h283);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    while (is_k(w)) w = 10'($urandom_range(0, 1023));
    return w;
  endfunction

  task automatic step(input logic [9:0] w, input logic rst, input logic e);
    bit cm, bnd;
    int exp_phase;
    rx_window = w;
    RESET     = rst;
    en        = e;
    @(posedge CRC_CKL);
    cm    = is_k(w);
    m_wv  = 0;
    m_clr = 0;
    if (rst) begin
      m_st = 0; m_good = 0; m_err = 0; m_realign = 0; m_clr = 1;
    end else if (!e) begin
      m_st = 0; m_good = 0; m_err = 0; m_clr = 1;
    end else begin
      bnd = (m_st != 0) && (cyc > m_anchor) && (((cyc - m_anchor) % 10) == 0);
      if (m_st == 0) begin
        if (cm) begin m_anchor = cyc; m_good = 1; m_st = 1; end
      end else if (m_st == 1) begin
        if (cm && bnd) begin
          m_good++;
          if (m_good >= ACQ) begin m_st = 2; m_err = 0; end
        end else if (cm) begin
          m_anchor = cyc; m_good = 1;
        end
      end else begin
        if (bnd) begin
          m_wv = 1; m_wo = int'(w); m_wc = cm;
          if (cm) m_err = 0;
        end else if (cm) begin
          m_err++;
          if (m_err >= LOSS) begin
            m_st = 0; m_err = 0;
            if (m_realign < 255) m_realign++;
          end
        end
      end
    end
    exp_phase = (m_st == 0) ? 0 : ((cyc - m_anchor) % 10);
    cyc++;
    #1;
    chk("locked", int'(locked), (m_st == 2) ? 1 : 0);
    chk("word_valid", int'(word_valid), int'(m_wv));
    chk("bit_phase", int'(bit_phase), exp_phase);
    chk("realign_cnt", int'(realign_cnt), m_realign);
    if (m_wv) begin
      chk("word_out", int'(word_out), m_wo);
      chk("word_is_comma", int'(word_is_comma), int'(m_wc));
    end
    if (m_clr) begin
      chk("word_out_clr", int'(word_out), 0);
      chk("word_is_comma_clr", int'(word_is_comma), 0);
    end
  endtask

  // Commas on cycles congruent to 'o' mod 10, random data elsewhere.
  task automatic run_stream(input int n, input int o, input bit alt);
    logic [9:0] w;
    for (int i = 0; i < n; i++) begin
      if ((cyc % 10) == o) begin
        w = (alt && disp) ? 10'h283 : 10'h17C;
        if (alt) disp = ~disp;
      end else begin
        w = rand_data();
      end
      step(w, 1'b0, 1'b1);
    end
  endtask

  initial begin
    int saved_realign;
    bit found;

    // Reset and idle.
    for (int i = 0; i < 3; i++) step(rand_data(), 1'b1, 1'b1);
    chk("reset_state", int'(dut.state_q), 0);
    for (int i = 0; i < 200; i++) step(rand_data(), 1'b0, 1'b1);
    chk("idle_state", int'(dut.state_q), 0);

    // Acquire with one disparity, commas five cycles in.
    off = (cyc + 5) % 10;
    run_stream(80, off, 1'b0);
    chk("acquired", int'(locked), 1);

    // Alternating disparities on the same boundary.
    run_stream(60, off, 1'b1);
    chk("locked_alt", int'(locked), 1);

    // Stream slips by four bits: lock lost after four misaligned commas, then regained.
    off = (off + 4) % 10;
    run_stream(100, off, 1'b0);
    chk("realign_after_loss", int'(realign_cnt), 1);
    chk("relocked", int'(locked), 1);

    // Disable for one clock while locked at phase 5.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      run_stream(1, off, 1'b0);
      if (locked && bit_phase == 4'd5) found = 1;
    end
    chk("phase5_reached", int'(found), 1);
    saved_realign = int'(realign_cnt);
    step(rand_data(), 1'b0, 1'b0);
    chk("disable_realign_kept", int'(realign_cnt), saved_realign);
    run_stream(60, off, 1'b0);
    chk("relock_after_disable", int'(locked), 1);

    // False comma in VERIFY: second comma three clocks late.
    step(rand_data(), 1'b1, 1'b1);
    step(rand_data(), 1'b0, 1'b1);
    step(10'h17C, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(rand_data(), 1'b0, 1'b1);
    off = cyc % 10;
    step(10'h283, 1'b0, 1'b1);
    chk("late_comma_phase", int'(bit_phase), 0);
    chk("late_comma_unlocked", int'(locked), 0);
    run_stream(40, off, 1'b0);
    chk("relock_new_phase", int'(locked), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on runtime.
  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
